// File: rtl/sc_nivel_controller.sv
// ============================================================================
// Module      : sc_nivel_controller
// Description : Level controller for a game. Counts points, steps the level
//               and strobes an external level register (Moore, registered).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_nivel_controller #(
    parameter int NIVEL_DATAWIDTH  = 2,
    parameter int POINTS_PER_LEVEL = 4,
    parameter int CNT_WIDTH        = 4
) (
    input  logic                       SC_NivelCtrl_CLOCK_50,
    input  logic                       SC_NivelCtrl_RESET_InHigh,
    input  logic                       SC_NivelCtrl_start_InLow,
    input  logic                       SC_NivelCtrl_point_InHigh,
    input  logic                       SC_NivelCtrl_gameover_InHigh,
    output logic [NIVEL_DATAWIDTH-1:0] SC_NivelCtrl_data_OutBUS,
    output logic                       SC_NivelCtrl_load_OutLow,
    output logic                       SC_NivelCtrl_clear_OutLow,
    output logic                       SC_NivelCtrl_maxlevel_OutHigh,
    output logic [2:0]                 SC_NivelCtrl_state_OutBUS
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_MAX   = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0]       C_CNT_LAST  = CNT_WIDTH'(POINTS_PER_LEVEL - 1);
    localparam logic [NIVEL_DATAWIDTH-1:0] C_LEVEL_TOP = {NIVEL_DATAWIDTH{1'b1}};

    state_t                     state_q, state_d;
    logic [NIVEL_DATAWIDTH-1:0] level_q, level_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       load_n_q, load_n_d;
    logic                       clear_n_q, clear_n_d;
    logic                       max_q, max_d;

    always_ff @(posedge SC_NivelCtrl_CLOCK_50) begin
        if (SC_NivelCtrl_RESET_InHigh) begin
            state_q   <= ST_IDLE;
            level_q   <= '0;
            cnt_q     <= '0;
            load_n_q  <= 1'b1;
            clear_n_q <= 1'b1;
            max_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            load_n_q  <= load_n_d;
            clear_n_q <= clear_n_d;
            max_q     <= max_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!SC_NivelCtrl_start_InLow) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Game over wins over a simultaneous point: no increment, no load.
                if (SC_NivelCtrl_gameover_InHigh) begin
                    state_d = ST_OVER;
                end else if (SC_NivelCtrl_point_InHigh) begin
                    if (cnt_q == C_CNT_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q + NIVEL_DATAWIDTH'(1);
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_LOAD: begin
                // Keep counting during the strobe; saturate only if a single
                // point per level would otherwise overflow the counter.
                if (SC_NivelCtrl_point_InHigh && (cnt_q != C_CNT_LAST)) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                if (SC_NivelCtrl_gameover_InHigh) begin
                    state_d = ST_OVER;
                end else if (level_q == C_LEVEL_TOP) begin
                    state_d = ST_MAX;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_MAX: begin
                if (SC_NivelCtrl_gameover_InHigh) state_d = ST_OVER;
            end
            ST_OVER: begin
                if (!SC_NivelCtrl_start_InLow) state_d = ST_CLEAR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Level and counter are already zero during the CLEAR cycle itself.
        if (state_d == ST_CLEAR) begin
            level_d = '0;
            cnt_d   = '0;
        end

        load_n_d  = (state_d != ST_LOAD);
        clear_n_d = (state_d != ST_CLEAR);
        max_d     = (state_d == ST_MAX);
    end

    assign SC_NivelCtrl_data_OutBUS      = level_q;
    assign SC_NivelCtrl_load_OutLow      = load_n_q;
    assign SC_NivelCtrl_clear_OutLow     = clear_n_q;
    assign SC_NivelCtrl_maxlevel_OutHigh = max_q;
    assign SC_NivelCtrl_state_OutBUS     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_sc_nivel_controller.sv
// ============================================================================
// Module      : tb_sc_nivel_controller
// Description : Self-checking bench for sc_nivel_controller (2-bit level, 4 points).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_nivel_controller;

    logic       clk;
    logic       rst;
    logic       start_n;
    logic       point;
    logic       gameover;
    logic [1:0] data;
    logic       load_n;
    logic       clear_n;
    logic       maxlvl;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    sc_nivel_controller #(
        .NIVEL_DATAWIDTH (2),
        .POINTS_PER_LEVEL(4),
        .CNT_WIDTH       (4)
    ) u_dut (
        .SC_NivelCtrl_CLOCK_50       (clk),
        .SC_NivelCtrl_RESET_InHigh   (rst),
        .SC_NivelCtrl_start_InLow    (start_n),
        .SC_NivelCtrl_point_InHigh   (point),
        .SC_NivelCtrl_gameover_InHigh(gameover),
        .SC_NivelCtrl_data_OutBUS    (data),
        .SC_NivelCtrl_load_OutLow    (load_n),
        .SC_NivelCtrl_clear_OutLow   (clear_n),
        .SC_NivelCtrl_maxlevel_OutHigh(maxlvl),
        .SC_NivelCtrl_state_OutBUS   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Every load strobe must match a level value queued by the stimulus.
    always @(negedge clk) begin
        if ((load_n == 1'b0) && (clear_n == 1'b0)) chk("strobe_excl", 0, 1);
        if (load_n == 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_load", int'(load_n), 1);
            end else begin
                chk("load_data", int'(data), exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        point = 1'b1;
        step();
        point = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start_game();
        start_n = 1'b0;
        step();
        chk("clear_state", int'(state), 1);
        chk("clear_strobe", int'(clear_n), 0);
        chk("clear_data", int'(data), 0);
        start_n = 1'b1;
        step();
        chk("play_state", int'(state), 2);
        chk("clear_release", int'(clear_n), 1);
    endtask

    initial begin
        rst      = 1'b1;
        start_n  = 1'b1;
        point    = 1'b0;
        gameover = 1'b0;
        do_reset();

        chk("rst_state", int'(state), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_load", int'(load_n), 1);
        chk("rst_clear", int'(clear_n), 1);
        chk("rst_max", int'(maxlvl), 0);

        // Inputs other than start are ignored in IDLE.
        point = 1'b1;
        gameover = 1'b1;
        step();
        point = 1'b0;
        gameover = 1'b0;
        chk("idle_hold", int'(state), 0);

        start_game();

        // Three levels, then MAX; further points are ignored.
        for (int lvl = 1; lvl <= 3; lvl++) begin
            for (int k = 0; k < 3; k++) pulse();
            chk("pre_load_state", int'(state), 2);
            exp_q.push_back(lvl);
            point = 1'b1;
            step();
            point = 1'b0;
            chk("load_state", int'(state), 3);
            chk("load_strobe", int'(load_n), 0);
            chk("load_level", int'(data), lvl);
            step();
            chk("post_load_state", int'(state), (lvl == 3) ? 4 : 2);
        end
        chk("max_flag", int'(maxlvl), 1);
        start_n = 1'b0;
        for (int k = 0; k < 5; k++) pulse();
        start_n = 1'b1;
        chk("max_state", int'(state), 4);
        chk("max_data", int'(data), 3);

        gameover = 1'b1;
        step();
        gameover = 1'b0;
        chk("over_from_max", int'(state), 5);
        chk("over_data", int'(data), 3);
        chk("over_max_clr", int'(maxlvl), 0);
        step();
        chk("over_hold", int'(state), 5);
        start_game();

        // Game over together with the 4th point: no load.
        for (int k = 0; k < 3; k++) pulse();
        point = 1'b1;
        gameover = 1'b1;
        step();
        point = 1'b0;
        gameover = 1'b0;
        chk("go_prio_state", int'(state), 5);
        chk("go_prio_load", int'(load_n), 1);
        chk("go_prio_data", int'(data), 0);
        start_game();

        // A point during LOAD is counted toward the next level.
        for (int k = 0; k < 3; k++) pulse();
        exp_q.push_back(1);
        point = 1'b1;
        step();
        chk("load2_state", int'(state), 3);
        step();
        point = 1'b0;
        chk("load2_exit", int'(state), 2);
        pulse();
        pulse();
        chk("cnt_carry_noload", int'(state), 2);
        exp_q.push_back(2);
        point = 1'b1;
        step();
        point = 1'b0;
        chk("carry_load_state", int'(state), 3);
        chk("carry_load_data", int'(data), 2);
        step();

        // Game over during LOAD: strobe completes, then OVER.
        for (int k = 0; k < 3; k++) pulse();
        exp_q.push_back(3);
        point = 1'b1;
        step();
        point = 1'b0;
        gameover = 1'b1;
        chk("go_load_strobe", int'(load_n), 0);
        step();
        gameover = 1'b0;
        chk("go_load_state", int'(state), 5);
        chk("go_load_data", int'(data), 3);

        // Reset during LOAD aborts the strobe.
        start_game();
        for (int k = 0; k < 3; k++) pulse();
        exp_q.push_back(1);
        point = 1'b1;
        step();
        point = 1'b0;
        chk("rl_in_load", int'(state), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rl_load", int'(load_n), 1);
        chk("rl_data", int'(data), 0);
        chk("rl_state", int'(state), 0);

        // Reset during CLEAR aborts the clear strobe.
        start_n = 1'b0;
        step();
        start_n = 1'b1;
        chk("rc_in_clear", int'(clear_n), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rc_clear", int'(clear_n), 1);
        chk("rc_state", int'(state), 0);

        step();
        chk("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sc_nivel_controller.md
SC_NIVEL_CONTROLLER -- requirements
Module: sc_nivel_controller

Interface
REQ-001 Parameter NIVEL_DATAWIDTH, default 2, SHALL set the level-bus width.
REQ-002 Parameter POINTS_PER_LEVEL, default 4, SHALL set the points needed per level step; legal range 1 to 2^CNT_WIDTH.
REQ-003 Parameter CNT_WIDTH, default 4, SHALL set the point-counter width.
REQ-004 SC_NivelCtrl_CLOCK_50 input 1 SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 SC_NivelCtrl_RESET_InHigh input 1 SHALL be the reset: synchronous, active-high.
REQ-006 SC_NivelCtrl_start_InLow input 1 SHALL request a new game when low.
REQ-007 SC_NivelCtrl_point_InHigh input 1 SHALL signal one scored point per high cycle.
REQ-008 SC_NivelCtrl_gameover_InHigh input 1 SHALL signal end of game when high.
REQ-009 SC_NivelCtrl_data_OutBUS output NIVEL_DATAWIDTH SHALL carry the current level value to the downstream level register data input.
REQ-010 SC_NivelCtrl_load_OutLow output 1 SHALL be the active-low load strobe to the level register.
REQ-011 SC_NivelCtrl_clear_OutLow output 1 SHALL be the active-low clear strobe to the level register.
REQ-012 SC_NivelCtrl_maxlevel_OutHigh output 1 SHALL be high while the top level is held.
REQ-013 SC_NivelCtrl_state_OutBUS output 3 SHALL expose the FSM state code.

Function
REQ-014 All outputs SHALL be registered (Moore); data_OutBUS SHALL equal the internal level register at all times.
REQ-015 The FSM SHALL have the states IDLE=0, CLEAR=1, PLAY=2, LOAD=3, MAX=4, OVER=5; codes 6 and 7 SHALL return to IDLE on the next edge.
REQ-016 IDLE: strobes high; start_InLow low SHALL move the FSM to CLEAR; all other inputs SHALL be ignored.
REQ-017 CLEAR SHALL last exactly one cycle with clear_OutLow low, level=0 and point counter=0, then SHALL move the FSM to PLAY.
REQ-018 PLAY: each point_InHigh cycle SHALL increment the point counter by one.
REQ-019 PLAY: when a point arrives with counter=POINTS_PER_LEVEL-1, the counter SHALL become 0, the level SHALL become level+1, and the FSM SHALL move to LOAD.
REQ-020 LOAD SHALL last exactly one cycle with load_OutLow low and data_OutBUS already holding the new level; the downstream register therefore captures on the edge after the final point edge plus one.
REQ-021 Points arriving during LOAD SHALL be counted; none SHALL be lost.
REQ-022 LOAD SHALL exit to MAX if level=2^NIVEL_DATAWIDTH-1, otherwise to PLAY.
REQ-023 MAX: maxlevel_OutHigh SHALL be high, points SHALL be ignored, and the level SHALL never wrap.
REQ-024 gameover_InHigh in PLAY or MAX SHALL move the FSM to OVER; in PLAY it SHALL take priority over a simultaneous point, with no increment and no load.
REQ-025 gameover_InHigh during LOAD SHALL let the strobe complete; the next state SHALL be OVER.
REQ-026 OVER SHALL hold level and counter; start_InLow low SHALL move the FSM to CLEAR.
REQ-027 start_InLow SHALL be ignored in CLEAR, PLAY, LOAD and MAX.
REQ-028 load_OutLow and clear_OutLow SHALL never be low in the same cycle.

Reset
REQ-029 Reset SHALL take priority over all inputs and SHALL set state=IDLE, level=0, counter=0, load_OutLow=1, clear_OutLow=1, maxlevel_OutHigh=0, state_OutBUS=0.
REQ-030 Reset asserted in LOAD or CLEAR SHALL abort the strobe, so it is high on the cycle after the reset edge.

Verification (NIVEL_DATAWIDTH=2, POINTS_PER_LEVEL=4)
REQ-031 Reset, then start_InLow low for 1 cycle -> clear_OutLow low exactly 1 cycle, then state=2, data=0.
REQ-032 3 point pulses -> no load; 4th pulse -> load_OutLow low 1 cycle with data=1, then state=2.
REQ-033 12 pulses -> loads with data 1, 2, 3; then maxlevel=1 and state=4; 5 further pulses -> no load, data stays 3.
REQ-034 gameover together with 4th point -> state=5, no load, data=0; start low -> clear, data=0.
REQ-035 Point pulse during LOAD -> counter=1 after return to PLAY; 3 more pulses -> next load with data=2.
REQ-036 Reset asserted during LOAD -> next cycle load_OutLow=1, data=0, state=0.
